// File: rtl/edge_arb_pkg.sv
// Shared types and helpers for the edge_event_arbiter slice.
// Optional timestamp support is selected with the EDGE_ARB_TSTAMP_EN macro.
package edge_arb_pkg;

    localparam int N_CH_DEF = 4;
    localparam int TS_W_DEF = 16;
    localparam int MAX_CH   = 16;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } rr_pick_t;

    // First set request at or after ptr, wrapping at n_ch.
    function automatic rr_pick_t rr_first(
        input logic [MAX_CH-1:0] req,
        input logic [3:0]        ptr,
        input int                n_ch
    );
        rr_pick_t   pick;
        logic [4:0] idx;
        pick = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            idx = {1'b0, ptr} + 5'(i);
            if (idx >= 5'(n_ch)) begin
                idx = idx - 5'(n_ch);
            end
            if ((i < n_ch) && !pick.found && req[idx[3:0]]) begin
                pick.found = 1'b1;
                pick.idx   = idx[3:0];
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/edge_det_ch.sv
// One monitored channel: edge detector plus a single-entry pending slot with overflow flag.
// With EDGE_ARB_TSTAMP_EN defined, the slot also captures a timestamp.
module edge_det_ch
    import edge_arb_pkg::*;
`ifdef EDGE_ARB_TSTAMP_EN
#(
    parameter int TS_W = TS_W_DEF
)
`endif
(
    input  logic            clk,
    input  logic            rst,
    input  logic            din,
    input  logic            rise_en,
    input  logic            fall_en,
    input  logic            grant,
    input  logic            ovf_clr,
`ifdef EDGE_ARB_TSTAMP_EN
    input  logic [TS_W-1:0] ts_now,
    output logic [TS_W-1:0] ts,
`endif
    output logic            pending,
    output logic            pend_rise,
    output logic            ovf
);

    logic prev_q,      prev_d;
    logic pending_q,   pending_d;
    logic pend_rise_q, pend_rise_d;
    logic ovf_q,       ovf_d;
    logic rise_hit;
    logic fall_hit;
    logic edge_hit;
    logic drop;
`ifdef EDGE_ARB_TSTAMP_EN
    logic [TS_W-1:0] ts_q, ts_d;
`endif

    always_comb begin
        rise_hit    = din & ~prev_q & rise_en;
        fall_hit    = ~din & prev_q & fall_en;
        edge_hit    = rise_hit | fall_hit;
        // A grant frees the slot in the same cycle, so only an ungranted full slot drops.
        drop        = edge_hit & pending_q & ~grant;
        prev_d      = din;
        pending_d   = pending_q;
        pend_rise_d = pend_rise_q;
        ovf_d       = ovf_q;
`ifdef EDGE_ARB_TSTAMP_EN
        ts_d        = ts_q;
`endif
        if (edge_hit && !drop) begin
            pending_d   = 1'b1;
            pend_rise_d = rise_hit;
`ifdef EDGE_ARB_TSTAMP_EN
            ts_d        = ts_now;
`endif
        end else if (grant) begin
            pending_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q      <= 1'b0;
            pending_q   <= 1'b0;
            pend_rise_q <= 1'b0;
            ovf_q       <= 1'b0;
`ifdef EDGE_ARB_TSTAMP_EN
            ts_q        <= '0;
`endif
        end else begin
            prev_q      <= prev_d;
            pending_q   <= pending_d;
            pend_rise_q <= pend_rise_d;
            ovf_q       <= ovf_d;
`ifdef EDGE_ARB_TSTAMP_EN
            ts_q        <= ts_d;
`endif
        end
    end

    assign pending   = pending_q;
    assign pend_rise = pend_rise_q;
    assign ovf       = ovf_q;
`ifdef EDGE_ARB_TSTAMP_EN
    assign ts        = ts_q;
`endif

endmodule

// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event controller with round-robin valid/ready event port.
// Define EDGE_ARB_TSTAMP_EN to add a free-running timestamp and the evt_ts output.
module edge_event_arbiter
    import edge_arb_pkg::*;
#(
    parameter  int N_CH = N_CH_DEF,
    parameter  int TS_W = TS_W_DEF,
    localparam int CH_W = $clog2(N_CH)
)(
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] in,
    input  logic [N_CH-1:0] rise_en,
    input  logic [N_CH-1:0] fall_en,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [CH_W-1:0] evt_ch,
    output logic            evt_rise,
`ifdef EDGE_ARB_TSTAMP_EN
    output logic [TS_W-1:0] evt_ts,
`endif
    output logic [N_CH-1:0] ovf,
    input  logic [N_CH-1:0] ovf_clr
);

    if (N_CH < 2 || N_CH > MAX_CH || TS_W < 1) begin : g_bad_cfg
        $error("edge_event_arbiter: N_CH must be 2..16 and TS_W >= 1");
    end

    logic [N_CH-1:0] pending;
    logic [N_CH-1:0] pend_rise;
    logic [N_CH-1:0] grant_vec;

    arb_state_e      state_q,     state_d;
    logic [CH_W-1:0] ptr_q,       ptr_d;
    logic            evt_valid_q, evt_valid_d;
    logic [CH_W-1:0] evt_ch_q,    evt_ch_d;
    logic            evt_rise_q,  evt_rise_d;

    logic [MAX_CH-1:0] req_wide;
    rr_pick_t          pick;
    logic              grant_en;
    logic [CH_W-1:0]   grant_idx;
    logic              take;

`ifdef EDGE_ARB_TSTAMP_EN
    logic [TS_W-1:0] ts_q, ts_d;
    logic [TS_W-1:0] evt_ts_q, evt_ts_d;
    logic [TS_W-1:0] ch_ts [N_CH];
`endif

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        edge_det_ch
`ifdef EDGE_ARB_TSTAMP_EN
        #(
            .TS_W (TS_W)
        )
`endif
        u_ch (
            .clk       (clk),
            .rst       (rst),
            .din       (in[gi]),
            .rise_en   (rise_en[gi]),
            .fall_en   (fall_en[gi]),
            .grant     (grant_vec[gi]),
            .ovf_clr   (ovf_clr[gi]),
`ifdef EDGE_ARB_TSTAMP_EN
            .ts_now    (ts_q),
            .ts        (ch_ts[gi]),
`endif
            .pending   (pending[gi]),
            .pend_rise (pend_rise[gi]),
            .ovf       (ovf[gi])
        );
    end

    always_comb begin
        req_wide            = '0;
        req_wide[N_CH-1:0]  = pending;
        pick                = rr_first(req_wide, 4'(ptr_q), N_CH);
        grant_en            = pick.found && ({1'b0, pick.idx} < 5'(N_CH));
        grant_idx           = pick.idx[CH_W-1:0];
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        evt_valid_d = evt_valid_q;
        evt_ch_d    = evt_ch_q;
        evt_rise_d  = evt_rise_q;
        grant_vec   = '0;
        take        = 1'b0;
`ifdef EDGE_ARB_TSTAMP_EN
        evt_ts_d    = evt_ts_q;
`endif
        case (state_q)
            IDLE: take = 1'b1;
            HOLD: begin
                if (evt_ready) begin
                    take        = 1'b1;
                    evt_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A free or just-accepted port picks up the next pending channel in the same cycle.
        if (take && grant_en) begin
            grant_vec[grant_idx] = 1'b1;
            evt_valid_d          = 1'b1;
            evt_ch_d             = grant_idx;
            evt_rise_d           = pend_rise[grant_idx];
            state_d              = HOLD;
            if (grant_idx == CH_W'(N_CH - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + 1'b1;
            end
`ifdef EDGE_ARB_TSTAMP_EN
            evt_ts_d             = ch_ts[grant_idx];
`endif
        end
    end

`ifdef EDGE_ARB_TSTAMP_EN
    always_comb begin
        ts_d = ts_q + 1'b1;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            evt_valid_q <= 1'b0;
            evt_ch_q    <= '0;
            evt_rise_q  <= 1'b0;
`ifdef EDGE_ARB_TSTAMP_EN
            ts_q        <= '0;
            evt_ts_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            evt_valid_q <= evt_valid_d;
            evt_ch_q    <= evt_ch_d;
            evt_rise_q  <= evt_rise_d;
`ifdef EDGE_ARB_TSTAMP_EN
            ts_q        <= ts_d;
            evt_ts_q    <= evt_ts_d;
`endif
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_ch    = evt_ch_q;
    assign evt_rise  = evt_rise_q;
`ifdef EDGE_ARB_TSTAMP_EN
    assign evt_ts    = evt_ts_q;
`endif

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Scoreboard bench for edge_event_arbiter: directed scenarios then random traffic
// against a per-cycle behavioural model of the edge/pending/round-robin rules.
module tb_edge_event_arbiter;

    localparam int N_CH = 4;
    localparam int CH_W = 2;
    localparam int TS_W = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N_CH-1:0] in_v;
    logic [N_CH-1:0] rise_en;
    logic [N_CH-1:0] fall_en;
    logic            evt_valid;
    logic            evt_ready;
    logic [CH_W-1:0] evt_ch;
    logic            evt_rise;
    logic [N_CH-1:0] ovf;
    logic [N_CH-1:0] ovf_clr;
`ifdef EDGE_ARB_TSTAMP_EN
    logic [TS_W-1:0] evt_ts;
`endif

    always #5 clk = ~clk;

    edge_event_arbiter #(
        .N_CH (N_CH),
        .TS_W (TS_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in_v),
        .rise_en   (rise_en),
        .fall_en   (fall_en),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_ch    (evt_ch),
        .evt_rise  (evt_rise),
`ifdef EDGE_ARB_TSTAMP_EN
        .evt_ts    (evt_ts),
`endif
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    typedef struct {
        int ch;
        int rise;
        int ts;
    } evt_t;

    evt_t exp_q[$];

    // Reference model state
    int m_prev [N_CH];
    int m_pend [N_CH];
    int m_type [N_CH];
    int m_ovf  [N_CH];
    int m_pts  [N_CH];
    int m_ptr;
    int m_valid;
    int m_tick;

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_ovf_bits();
        int v = 0;
        for (int i = 0; i < N_CH; i++) if (m_ovf[i] != 0) v |= (1 << i);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) begin
            m_prev[i] = 0; m_pend[i] = 0; m_type[i] = 0; m_ovf[i] = 0; m_pts[i] = 0;
        end
        m_ptr = 0; m_valid = 0; m_tick = 0;
        exp_q.delete();
    endtask

    // One clock edge of the specified behaviour, using the inputs present at that edge.
    task automatic model_step();
        int g;
        g = -1;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_valid == 0 || evt_ready) begin
            for (int k = 0; k < N_CH; k++) begin
                int c = (m_ptr + k) % N_CH;
                if (g < 0 && m_pend[c] != 0) g = c;
            end
            if (g >= 0) begin
                evt_t e;
                e.ch = g; e.rise = m_type[g]; e.ts = m_pts[g];
                exp_q.push_back(e);
                m_valid = 1;
                m_ptr = (g + 1) % N_CH;
            end else begin
                m_valid = 0;
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            int r, f, dropped;
            r = (in_v[i] && m_prev[i] == 0 && rise_en[i]) ? 1 : 0;
            f = (!in_v[i] && m_prev[i] != 0 && fall_en[i]) ? 1 : 0;
            dropped = 0;
            if (r != 0 || f != 0) begin
                if (m_pend[i] != 0 && i != g) begin
                    dropped = 1;
                end else begin
                    m_pend[i] = 1; m_type[i] = r; m_pts[i] = m_tick;
                end
            end else if (i == g) begin
                m_pend[i] = 0;
            end
            if (dropped != 0) m_ovf[i] = 1;
            else if (ovf_clr[i]) m_ovf[i] = 0;
            m_prev[i] = in_v[i] ? 1 : 0;
        end
        m_tick = (m_tick + 1) % (1 << TS_W);
    endtask

    task automatic cycle(input logic [N_CH-1:0] i_v, input logic [N_CH-1:0] re,
                         input logic [N_CH-1:0] fe, input logic rdy,
                         input logic [N_CH-1:0] clr, input logic r);
        in_v = i_v; rise_en = re; fall_en = fe; evt_ready = rdy; ovf_clr = clr; rst = r;
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Monitor: samples on the falling edge, pops the scoreboard on each handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("evt_valid", int'(evt_valid), m_valid);
                check("ovf", int'(ovf), model_ovf_bits());
                if (evt_valid && exp_q.size() > 0) begin
                    check("evt_ch", int'(evt_ch), exp_q[0].ch);
                    check("evt_rise", int'(evt_rise), exp_q[0].rise);
`ifdef EDGE_ARB_TSTAMP_EN
                    check("evt_ts", int'(evt_ts), exp_q[0].ts);
`endif
                end
                if (evt_valid && evt_ready && !rst) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL accept_unexpected: got ch %0d rise %0d expected no event", evt_ch, evt_rise);
                    end else begin
                        evt_t e;
                        e = exp_q.pop_front();
                        $display("accept ch=%0d rise=%0d ts=%0d", e.ch, e.rise, e.ts);
                    end
                end
            end
        end
    end

    initial begin
        logic [N_CH-1:0] cur;
        model_reset();
        cycle('0, '0, '0, 1'b0, '0, 1'b1);
        cycle('0, '0, '0, 1'b0, '0, 1'b1);
        check("reset_evt_valid", int'(evt_valid), 0);
        check("reset_evt_ch", int'(evt_ch), 0);
        check("reset_evt_rise", int'(evt_rise), 0);
        check("reset_ovf", int'(ovf), 0);
        mon_en = 1'b1;

        // ch1 rising with only ch1 enabled
        cycle(4'b0000, 4'b0010, 4'b0000, 1'b1, '0, 1'b0);
        cycle(4'b0010, 4'b0010, 4'b0000, 1'b1, '0, 1'b0);
        repeat (4) cycle(4'b0010, 4'b0010, 4'b0000, 1'b1, '0, 1'b0);

        // simultaneous rises on ch0, ch2, ch3
        cycle(4'b0000, 4'b1111, 4'b0000, 1'b1, '0, 1'b0);
        cycle(4'b1101, 4'b1111, 4'b0000, 1'b1, '0, 1'b0);
        repeat (5) cycle(4'b1101, 4'b1111, 4'b0000, 1'b1, '0, 1'b0);

        // ch2 held with ready low, re-armed, then overflowed; then cleared
        cycle(4'b0000, 4'b0100, 4'b0100, 1'b0, '0, 1'b0);
        cycle(4'b0100, 4'b0100, 4'b0100, 1'b0, '0, 1'b0);
        cycle(4'b0100, 4'b0100, 4'b0100, 1'b0, '0, 1'b0);
        cycle(4'b0000, 4'b0100, 4'b0100, 1'b0, '0, 1'b0);
        cycle(4'b0100, 4'b0100, 4'b0100, 1'b0, '0, 1'b0);
        cycle(4'b0100, 4'b0100, 4'b0100, 1'b0, 4'b0100, 1'b0);
        repeat (4) cycle(4'b0100, 4'b0100, 4'b0100, 1'b1, '0, 1'b0);

        // ch0 grant coinciding with a new ch0 edge
        cycle(4'b0000, 4'b0001, 4'b0001, 1'b1, '0, 1'b0);
        cycle(4'b0001, 4'b0001, 4'b0001, 1'b1, '0, 1'b0);
        cycle(4'b0000, 4'b0001, 4'b0001, 1'b1, '0, 1'b0);
        repeat (4) cycle(4'b0000, 4'b0001, 4'b0001, 1'b1, '0, 1'b0);

        // in[3] high through reset release, then reset while an event is held
        cycle(4'b1000, 4'b1000, 4'b0000, 1'b0, '0, 1'b1);
        cycle(4'b1000, 4'b1000, 4'b0000, 1'b0, '0, 1'b0);
        cycle(4'b1000, 4'b1000, 4'b0000, 1'b0, '0, 1'b0);
        cycle(4'b1000, 4'b1000, 4'b0000, 1'b0, '0, 1'b1);
        repeat (3) cycle(4'b1000, 4'b1000, 4'b0000, 1'b1, '0, 1'b0);

        // randomized traffic
        cur = in_v;
        for (int n = 0; n < 3000; n++) begin
            logic [N_CH-1:0] flip, re, fe, clr;
            logic rdy, r;
            flip = ($urandom_range(0, 2) == 0) ? N_CH'($urandom) : '0;
            cur  = cur ^ flip;
            re   = N_CH'($urandom) | N_CH'($urandom);
            fe   = N_CH'($urandom);
            rdy  = ($urandom_range(0, 3) != 0);
            clr  = ($urandom_range(0, 7) == 0) ? N_CH'($urandom) : '0;
            r    = ($urandom_range(0, 299) == 0);
            cycle(cur, re, fe, rdy, clr, r);
        end

        // drain
        repeat (20) cycle(cur, 4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b0);
        check("drain_queue_empty", exp_q.size(), 0);
        check("drain_evt_valid", int'(evt_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
